// File: rtl/display_scan.sv
// -----------------------------------------------------------------------------
// display_scan
//
// Time-multiplexing scan controller for the 4-digit 7-segment display block.
// Walks a digit slot index 0..3, splits every slot into 16 PWM sub-steps of
// STEP_CYCLES clocks each, keeps sub-step 0 dark as inter-digit blanking and
// lights sub-steps 1..brightness. A frame counter drives a blink phase used to
// hide selected digits and/or the colon dot while the clock is in set mode.
//
// Parameters:
//   STEP_CYCLES  - clock cycles per PWM sub-step (>= 1); slot = 16*STEP_CYCLES
//   BLINK_FRAMES - full 4-digit frames per blink half-period (>= 1)
//
// Ports:
//   i_Clk           - system clock
//   i_Reset         - synchronous active-high reset
//   i_Enable        - scan run; low freezes all counters and blanks outputs
//   i_Brightness    - duty level 0..15, latched at slot start
//   i_Blink_Mask    - bit3 = digit at select 0 ... bit0 = digit at select 3
//   i_Dot_Enable    - colon dot requested
//   i_Dot_Blink     - colon blinks with the blink phase
//   o_Select        - current digit slot index, drives the display mux
//   o_Enable_Digits - one-hot digit gate, bit3 = select 0 ... bit0 = select 3
//   o_Enable_Dot    - dot gate (display block lights it only in select 1)
//   o_Slot_Start    - one-cycle pulse in the first cycle of every slot
// -----------------------------------------------------------------------------
module display_scan #(
    parameter int unsigned STEP_CYCLES  = 750,
    parameter int unsigned BLINK_FRAMES = 94
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Enable,
    input  logic [3:0] i_Brightness,
    input  logic [3:0] i_Blink_Mask,
    input  logic       i_Dot_Enable,
    input  logic       i_Dot_Blink,
    output logic [1:0] o_Select,
    output logic [3:0] o_Enable_Digits,
    output logic       o_Enable_Dot,
    output logic       o_Slot_Start
);

    localparam int unsigned CycW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CycW-1:0] CycLast = CycW'(STEP_CYCLES - 1);
    localparam logic [FrmW-1:0] FrmLast = FrmW'(BLINK_FRAMES - 1);

    // Scan position: the (slot, sub-step, cycle) that the next enabled edge
    // presents on the outputs. It only advances on enabled edges, so a paused
    // scan resumes exactly where it stopped.
    logic [CycW-1:0] cyc_q, cyc_d;
    logic [3:0]      k_q, k_d;
    logic [1:0]      sel_q, sel_d;
    logic [FrmW-1:0] frame_q, frame_d;
    logic            phase_q, phase_d;

    // Per-slot snapshots of brightness and blink mask.
    logic [3:0]      bright_q, bright_d;
    logic [3:0]      mask_q, mask_d;

    // Registered outputs.
    logic [1:0]      select_q, select_d;
    logic [3:0]      digits_q, digits_d;
    logic            dot_q, dot_d;
    logic            start_q, start_d;

    logic            cyc_last;
    logic            k_last;
    logic            frame_last;
    logic            slot_start;
    logic [3:0]      bright_eff;
    logic [3:0]      mask_eff;
    logic            in_window;
    logic            digit_hidden;

    always_comb begin
        cyc_last   = (cyc_q == CycLast);
        k_last     = (k_q == 4'hf);
        frame_last = (frame_q == FrmLast);
        slot_start = (k_q == 4'd0) && (cyc_q == '0);

        // At slot start the fresh inputs are used directly so the snapshot and
        // the first decision of the slot always agree.
        bright_eff = slot_start ? i_Brightness : bright_q;
        mask_eff   = slot_start ? i_Blink_Mask : mask_q;

        // Sub-step 0 is the blanking step; lit steps are 1..brightness.
        in_window    = (k_q != 4'd0) && (k_q <= bright_eff);
        digit_hidden = phase_q && mask_eff[2'd3 - sel_q];
    end

    always_comb begin
        cyc_d    = cyc_q;
        k_d      = k_q;
        sel_d    = sel_q;
        frame_d  = frame_q;
        phase_d  = phase_q;
        bright_d = bright_q;
        mask_d   = mask_q;
        select_d = select_q;
        digits_d = 4'b0000;
        dot_d    = 1'b0;
        start_d  = 1'b0;

        if (i_Enable) begin
            select_d = sel_q;
            start_d  = slot_start;
            if (slot_start) begin
                bright_d = i_Brightness;
                mask_d   = i_Blink_Mask;
            end

            if (in_window && !digit_hidden) begin
                digits_d = 4'b1000 >> sel_q;
            end
            dot_d = i_Dot_Enable && in_window && !(i_Dot_Blink && phase_q);

            // Advance the scan position.
            if (cyc_last) begin
                cyc_d = '0;
                if (k_last) begin
                    k_d   = 4'd0;
                    sel_d = sel_q + 2'd1;
                    if (sel_q == 2'd3) begin
                        if (frame_last) begin
                            frame_d = '0;
                            phase_d = ~phase_q;
                        end else begin
                            frame_d = frame_q + FrmW'(1);
                        end
                    end
                end else begin
                    k_d = k_q + 4'd1;
                end
            end else begin
                cyc_d = cyc_q + CycW'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            cyc_q    <= '0;
            k_q      <= 4'd0;
            sel_q    <= 2'd0;
            frame_q  <= '0;
            phase_q  <= 1'b0;
            bright_q <= 4'd0;
            mask_q   <= 4'd0;
            select_q <= 2'd0;
            digits_q <= 4'd0;
            dot_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            cyc_q    <= cyc_d;
            k_q      <= k_d;
            sel_q    <= sel_d;
            frame_q  <= frame_d;
            phase_q  <= phase_d;
            bright_q <= bright_d;
            mask_q   <= mask_d;
            select_q <= select_d;
            digits_q <= digits_d;
            dot_q    <= dot_d;
            start_q  <= start_d;
        end
    end

    assign o_Select        = select_q;
    assign o_Enable_Digits = digits_q;
    assign o_Enable_Dot    = dot_q;
    assign o_Slot_Start    = start_q;

endmodule
